// File: rtl/peri_arb_pkg.sv
// Shared types and helpers for the peripheral bus arbiter.
// Holds the FSM state type, bus field widths and the round-robin picker.
package peri_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int PERI_DW  = 32;
    localparam int PERI_AW  = 32;
    localparam int PERI_BEW = 4;

    // Widest host count the picker handles; hosts above num_host are ignored.
    localparam int MAX_HOST   = 4;
    localparam int HOST_IDX_W = 2;

    typedef struct packed {
        logic                  valid;
        logic [HOST_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requesting host when scanning ptr, ptr+1, ... modulo num_host.
    function automatic rr_pick_t rr_pick(input logic [MAX_HOST-1:0]   req,
                                         input logic [HOST_IDX_W-1:0] ptr,
                                         input int                    num_host);
        rr_pick_t res;
        int       cand;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_HOST; i++) begin
            if (i < num_host && !res.valid) begin
                cand = (int'(ptr) + i) % num_host;
                if (req[cand]) begin
                    res.valid = 1'b1;
                    res.idx   = cand[HOST_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/peri_arb_id_fifo.sv
// In-order ID FIFO: remembers which host owns each granted-but-unanswered
// transaction. The head is read combinationally so a response can be routed
// in the same cycle it arrives. Pushes when full and pops when empty are
// ignored.
module peri_arb_id_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between NUM_HOST hosts.
// A presented-but-ungranted request is locked (HOLD) until granted; response
// routing uses an in-order ID FIFO. Optional sticky protocol error flag is
// built when PERI_ARB_ERR_CHECK_EN is defined.
module peri_bus_arbiter
    import peri_arb_pkg::*;
#(
    parameter  int NUM_HOST        = 2,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int ID_W            = $clog2(NUM_HOST)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_HOST-1:0]          host_req,
    input  logic [NUM_HOST*PERI_AW-1:0]  host_addr,
    input  logic [NUM_HOST-1:0]          host_write,
    input  logic [NUM_HOST*PERI_BEW-1:0] host_be,
    input  logic [NUM_HOST*PERI_DW-1:0]  host_wdata,
    output logic [NUM_HOST-1:0]          host_gnt,
    output logic [NUM_HOST-1:0]          host_rvalid,
    output logic [PERI_DW-1:0]           host_rdata,
    output logic                         peri_req,
    output logic [PERI_AW-1:0]           peri_addr,
    output logic                         peri_write,
    output logic [PERI_BEW-1:0]          peri_be,
    output logic [PERI_DW-1:0]           peri_wdata,
    input  logic                         peri_gnt,
    input  logic                         peri_rvalid,
    input  logic [PERI_DW-1:0]           peri_rdata,
    output logic                         arb_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [PERI_AW-1:0]  addr_a  [NUM_HOST];
    logic [PERI_BEW-1:0] be_a    [NUM_HOST];
    logic [PERI_DW-1:0]  wdata_a [NUM_HOST];

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     held_id_q, held_id_d;
    logic [ID_W-1:0]     sel_id;
    logic [ID_W-1:0]     win_id;
    rr_pick_t            pick;
    logic                issue;
    logic                push;
    logic                pop;
    logic                hold_drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ID_W-1:0]     fifo_head;
    logic [CNT_W-1:0]    fifo_count_unused;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_HOST - 1)) ? '0 : id + 1'b1;
    endfunction

    // Split the flat per-host payload buses and build per-host grant/rvalid.
    generate
        for (genvar gi = 0; gi < NUM_HOST; gi++) begin : g_host
            assign addr_a[gi]      = host_addr[gi*PERI_AW +: PERI_AW];
            assign be_a[gi]        = host_be[gi*PERI_BEW +: PERI_BEW];
            assign wdata_a[gi]     = host_wdata[gi*PERI_DW +: PERI_DW];
            assign host_gnt[gi]    = push && (sel_id == ID_W'(gi));
            assign host_rvalid[gi] = pop && (fifo_head == ID_W'(gi));
        end
    endgenerate

    assign pick   = rr_pick(MAX_HOST'(host_req), HOST_IDX_W'(rr_ptr_q), NUM_HOST);
    assign win_id = ID_W'(pick.idx);

    // Arbitration state, round-robin pointer and locked host.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            held_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            held_id_q <= held_id_d;
        end
    end

    // Pick or hold the forwarded host; full only ever blocks a fresh pick.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        held_id_d = held_id_q;
        sel_id    = win_id;
        issue     = 1'b0;
        push      = 1'b0;
        hold_drop = 1'b0;
        unique case (state_q)
            ARB: begin
                sel_id = win_id;
                issue  = pick.valid && !fifo_full;
                if (issue) begin
                    if (peri_gnt) begin
                        push     = 1'b1;
                        rr_ptr_d = wrap_inc(win_id);
                    end else begin
                        held_id_d = win_id;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                sel_id = held_id_q;
                issue  = 1'b1;
                if (!host_req[held_id_q]) begin
                    hold_drop = 1'b1;
                    state_d   = ARB;
                end else if (peri_gnt) begin
                    push     = 1'b1;
                    rr_ptr_d = wrap_inc(held_id_q);
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign peri_req   = issue;
    assign peri_addr  = issue ? addr_a[sel_id]     : '0;
    assign peri_write = issue ? host_write[sel_id] : 1'b0;
    assign peri_be    = issue ? be_a[sel_id]       : '0;
    assign peri_wdata = issue ? wdata_a[sel_id]    : '0;

    assign pop        = peri_rvalid && !fifo_empty;
    assign host_rdata = pop ? peri_rdata : '0;

    peri_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (sel_id),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused),
        .head_o  (fifo_head)
    );

`ifdef PERI_ARB_ERR_CHECK_EN
    logic arb_err_q;

    // Sticky flag: orphan response or a host abandoning a locked request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_err_q <= 1'b0;
        end else if ((peri_rvalid && fifo_empty) || hold_drop) begin
            arb_err_q <= 1'b1;
        end
    end

    assign arb_err = arb_err_q;
`else
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Bench for peri_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model (outstanding-ID queue,
// round-robin pointer and locked host).
module tb_peri_bus_arbiter;

    localparam int N       = 2;
    localparam int MAX_OUT = 2;
`ifdef PERI_ARB_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      host_req;
    logic [N*32-1:0]   host_addr;
    logic [N-1:0]      host_write;
    logic [N*4-1:0]    host_be;
    logic [N*32-1:0]   host_wdata;
    logic [N-1:0]      host_gnt;
    logic [N-1:0]      host_rvalid;
    logic [31:0]       host_rdata;
    logic              peri_req;
    logic [31:0]       peri_addr;
    logic              peri_write;
    logic [3:0]        peri_be;
    logic [31:0]       peri_wdata;
    logic              peri_gnt;
    logic              peri_rvalid;
    logic [31:0]       peri_rdata;
    logic              arb_err;

    always #5 clk = ~clk;

    peri_bus_arbiter #(
        .NUM_HOST        (N),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_write  (host_write),
        .host_be     (host_be),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .peri_req    (peri_req),
        .peri_addr   (peri_addr),
        .peri_write  (peri_write),
        .peri_be     (peri_be),
        .peri_wdata  (peri_wdata),
        .peri_gnt    (peri_gnt),
        .peri_rvalid (peri_rvalid),
        .peri_rdata  (peri_rdata),
        .arb_err     (arb_err)
    );

    // Host-side stimulus state
    bit          h_req   [N];
    logic [31:0] h_addr  [N];
    logic        h_write [N];
    logic [3:0]  h_be    [N];
    logic [31:0] h_wdata [N];
    bit          drv_gnt;
    bit          drv_rvalid;
    logic [31:0] drv_rdata;

    // Reference model state
    int oq[$];       // host IDs granted and not yet answered, in grant order
    int per_q[$];    // cycle each transaction was accepted by the peripheral
    int rr;
    int locked;
    bit err_m;

    int n_checks;
    int n_errs;
    int cyc;
    bit verbose;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [N-1:0] obs_gnt;
    logic [N-1:0] obs_rv;
    logic        obs_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            if (n_errs <= 40)
                $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_host(input int h, input logic [31:0] a, input logic w,
                            input logic [3:0] be, input logic [31:0] d);
        h_req[h]   = 1'b1;
        h_addr[h]  = a;
        h_write[h] = w;
        h_be[h]    = be;
        h_wdata[h] = d;
    endtask

    function automatic bit rsp_ready();
        return per_q.size() > 0 && per_q[0] < cyc;
    endfunction

    // One bus cycle: drive at negedge, check combinational outputs, advance model.
    task automatic step();
        int          win;
        bit          issue;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_write;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        logic [31:0] e_rdata;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            host_req[i]           = h_req[i];
            host_addr[32*i +: 32] = h_addr[i];
            host_write[i]         = h_write[i];
            host_be[4*i +: 4]     = h_be[i];
            host_wdata[32*i +: 32] = h_wdata[i];
        end
        peri_gnt    = drv_gnt;
        peri_rvalid = drv_rvalid;
        peri_rdata  = drv_rdata;
        #1;
        win   = -1;
        issue = 1'b0;
        if (locked >= 0) begin
            win   = locked;
            issue = 1'b1;
        end else if (oq.size() < MAX_OUT) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && h_req[(rr + k) % N]) win = (rr + k) % N;
            end
            issue = (win >= 0);
        end
        e_req = issue; e_addr = '0; e_write = 1'b0; e_be = '0; e_wdata = '0; e_gnt = '0;
        if (issue) begin
            e_addr = h_addr[win]; e_write = h_write[win]; e_be = h_be[win]; e_wdata = h_wdata[win];
            if (drv_gnt) e_gnt[win] = 1'b1;
        end
        e_rv = '0; e_rdata = '0;
        if (drv_rvalid && oq.size() > 0) begin
            e_rv[oq[0]] = 1'b1;
            e_rdata     = drv_rdata;
        end
        check_val("peri_req",    32'(peri_req),    32'(e_req));
        check_val("peri_addr",   peri_addr,        e_addr);
        check_val("peri_write",  32'(peri_write),  32'(e_write));
        check_val("peri_be",     32'(peri_be),     32'(e_be));
        check_val("peri_wdata",  peri_wdata,       e_wdata);
        check_val("host_gnt",    32'(host_gnt),    32'(e_gnt));
        check_val("host_rvalid", 32'(host_rvalid), 32'(e_rv));
        check_val("host_rdata",  host_rdata,       e_rdata);
        check_val("arb_err",     32'(arb_err),     32'(ERR_EN && err_m));
        obs_req = peri_req; obs_addr = peri_addr; obs_wdata = peri_wdata;
        obs_gnt = host_gnt; obs_rv = host_rvalid; obs_err = arb_err;
        if (verbose)
            $display("cyc %0d: req=%b peri_req=%b addr=%h gnt=%b rvalid=%b rdata=%h err=%b",
                     cyc, host_req, peri_req, peri_addr, host_gnt, host_rvalid, host_rdata, arb_err);
        // advance model
        if (drv_rvalid && oq.size() == 0) err_m = 1'b1;
        if (drv_rvalid && oq.size() > 0) void'(oq.pop_front());
        if (drv_rvalid && per_q.size() > 0) void'(per_q.pop_front());
        if (issue && drv_gnt) begin
            oq.push_back(win);
            per_q.push_back(cyc);
            rr       = (win + 1) % N;
            locked   = -1;
            h_req[win] = 1'b0;
        end else if (issue) begin
            locked = win;
        end
        drv_gnt    = 1'b0;
        drv_rvalid = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) h_req[i] = 1'b0;
        host_req = '0; peri_gnt = 1'b0; peri_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        oq.delete(); per_q.delete();
        rr = 0; locked = -1; err_m = 1'b0;
        cyc += 2;
    endtask

    task automatic drain();
        for (int g = 0; g < 8 && per_q.size() > 0; g++) begin
            drv_rvalid = rsp_ready();
            drv_rdata  = $urandom;
            step();
        end
        check_val("drain_done", 32'(per_q.size()), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errs = 0; cyc = 0; verbose = 1'b1;
        rst_n = 1'b0;
        host_req = '0; host_addr = '0; host_write = '0; host_be = '0; host_wdata = '0;
        peri_gnt = 1'b0; peri_rvalid = 1'b0; peri_rdata = '0;
        drv_gnt = 1'b0; drv_rvalid = 1'b0; drv_rdata = '0;
        for (int i = 0; i < N; i++) begin
            h_req[i] = 1'b0; h_addr[i] = '0; h_write[i] = 1'b0; h_be[i] = '0; h_wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // reset state: nothing requested, all outputs quiet
        step();
        check_val("rst_req", 32'(obs_req), 32'd0);
        check_val("rst_gnt", 32'(obs_gnt), 32'd0);

        // single host write, granted at once, answered next cycle
        set_host(0, 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
        drv_gnt = 1'b1;
        step();
        check_val("t1_gnt",   32'(obs_gnt), 32'd1);
        check_val("t1_addr",  obs_addr,     32'h0000_1000);
        check_val("t1_wdata", obs_wdata,    32'hDEAD_BEEF);
        drv_rvalid = 1'b1; drv_rdata = 32'h1234_5678;
        step();
        check_val("t1_rvalid", 32'(obs_rv), 32'd1);

        // host1 wins (pointer now 1) and is held while grant stalls
        set_host(1, 32'h0000_2004, 1'b0, 4'h3, 32'h0);
        set_host(0, 32'h0000_3000, 1'b1, 4'hF, 32'hCAFE_0001);
        for (int k = 0; k < 4; k++) begin
            drv_gnt = (k == 3);
            step();
            check_val("t3_addr", obs_addr,     32'h0000_2004);
            check_val("t3_gnt",  32'(obs_gnt), (k == 3) ? 32'd2 : 32'd0);
        end
        drv_gnt = 1'b1;
        step();
        check_val("t3_gnt0", 32'(obs_gnt), 32'd1);
        drain();

        // both hosts continuously requesting: grants alternate
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int h = 0; h < N; h++)
                if (!h_req[h]) set_host(h, 32'h100 * (h + 1) + 32'(k), 1'b0, 4'hF, $urandom);
            drv_gnt = 1'b1;
            drv_rvalid = rsp_ready();
            drv_rdata = $urandom;
            step();
            check_val("t2_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) check_val("t2_rvalid", 32'(obs_rv), (k % 2 == 1) ? 32'd1 : 32'd2);
        end
        for (int h = 0; h < N; h++) h_req[h] = 1'b0;
        drain();

        // outstanding limit: third request blocked, even during a pop
        do_reset();
        set_host(0, 32'h40, 1'b0, 4'hF, 0); drv_gnt = 1'b1; step();
        set_host(1, 32'h44, 1'b0, 4'hF, 0); drv_gnt = 1'b1; step();
        set_host(0, 32'h48, 1'b0, 4'hF, 0); drv_gnt = 1'b1; step();
        check_val("t4_full_req", 32'(obs_req), 32'd0);
        check_val("t4_full_gnt", 32'(obs_gnt), 32'd0);
        drv_gnt = 1'b1; drv_rvalid = 1'b1; drv_rdata = 32'hA5A5_0000; step();
        check_val("t4_pop_req", 32'(obs_req), 32'd0);
        check_val("t4_pop_rv",  32'(obs_rv),  32'd1);
        drv_gnt = 1'b1; step();
        check_val("t4_resume", 32'(obs_gnt), 32'd1);
        drain();

        // response with nothing outstanding
        drv_rvalid = 1'b1; drv_rdata = 32'hFFFF_FFFF; step();
        check_val("t5_rv", 32'(obs_rv), 32'd0);
        step();
        check_val("t5_err", 32'(obs_err), 32'(ERR_EN));

        // reset with two outstanding clears FIFO and pointer
        set_host(1, 32'h80, 1'b0, 4'hF, 0); drv_gnt = 1'b1; step();
        set_host(0, 32'h84, 1'b0, 4'hF, 0); drv_gnt = 1'b1; step();
        do_reset();
        step();
        check_val("t6_req",  32'(obs_req), 32'd0);
        check_val("t6_addr", obs_addr,     32'd0);
        check_val("t6_err",  32'(obs_err), 32'd0);
        drv_rvalid = 1'b1; drv_rdata = 32'h5555_AAAA; step();
        check_val("t6_late_rv", 32'(obs_rv), 32'd0);
        set_host(0, 32'h90, 1'b0, 4'hF, 0);
        set_host(1, 32'h94, 1'b0, 4'hF, 0);
        drv_gnt = 1'b1; step();
        check_val("t6_rr", 32'(obs_gnt), 32'd1);

        // random traffic against the model
        do_reset();
        verbose = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int h = 0; h < N; h++)
                if (!h_req[h] && $urandom_range(0, 9) < 4)
                    set_host(h, $urandom, 1'($urandom), 4'($urandom), $urandom);
            drv_gnt    = ($urandom_range(0, 2) != 0);
            drv_rvalid = rsp_ready() && ($urandom_range(0, 1) == 1);
            drv_rdata  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/peri_bus_arbiter.md
Name: peri_bus_arbiter

Overview:
- Shares the single on-chip peripheral bus (peri_* req/gnt/rvalid protocol) between NUM_HOST requesters, e.g. the core complex and a DMA engine.
- Sits between the requesters and the peripherals block.
- Arbitration is round-robin, and an in-flight request stays stable until granted.
- Responses return in order and are routed back to the issuing host through an ID FIFO.

Parameters:
- NUM_HOST, 2, number of requesters (2..4).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..4).
- ID_W, $clog2(NUM_HOST), host ID width (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- host_req  in  NUM_HOST  per-host request
- host_addr  in  NUM_HOST*32  per-host address, host i at [32i+31:32i]
- host_write  in  NUM_HOST  per-host write enable
- host_be  in  NUM_HOST*4  per-host byte enables
- host_wdata  in  NUM_HOST*32  per-host write data
- host_gnt  out  NUM_HOST  per-host grant
- host_rvalid  out  NUM_HOST  per-host response valid
- host_rdata  out  32  response data, broadcast to all hosts and qualified by host_rvalid
- peri_req  out  1  request to peripherals
- peri_addr  out  32  forwarded address
- peri_write  out  1  forwarded write enable
- peri_be  out  4  forwarded byte enables
- peri_wdata  out  32  forwarded write data
- peri_gnt  in  1  peripheral grant
- peri_rvalid  in  1  peripheral response valid
- peri_rdata  in  32  peripheral read data
- arb_err  out  1  sticky protocol error; see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; all state is sampled on the clk rising edge while rst_n==0.
- Reset values:
  - FSM=ARB, rr_ptr=0, held_id=0, FIFO empty (count=0), arb_err=0.
  - All outputs are combinationally 0 while no request is pending.
- Host protocol: a host holds req and its payload stable until gnt. Response (rvalid) arrives no earlier than the cycle after gnt, in grant order.

FSM:
- ARB
  - Winner = first requesting host scanning rr_ptr, rr_ptr+1, ... mod NUM_HOST.
  - If any host requests and count<MAX_OUTSTANDING: peri_req=1 and the winner's payload is forwarded on peri_*.
  - host_gnt[winner] = peri_gnt (combinational, same cycle).
  - If peri_gnt: push winner ID, rr_ptr <= winner+1 mod NUM_HOST, stay in ARB.
  - Else: held_id <= winner, go to HOLD.
- HOLD
  - Forward host held_id only, regardless of other requests; peri_req=1 unconditionally (FIFO is not full here).
  - On peri_gnt: push held_id, rr_ptr <= held_id+1, go to ARB.
  - If the host drops req in HOLD (protocol violation): return to ARB with no push, and flag it under the Optional Feature.

ID FIFO:
- Depth MAX_OUTSTANDING, entries ID_W bits, pointers wrap modulo depth.
- On peri_rvalid with count>0: host_rvalid[head] = 1 in the same cycle (combinational), then pop.
- Simultaneous push and pop: count unchanged, both take effect.
- Full (count==MAX_OUTSTANDING): in ARB, peri_req=0 and no host_gnt, even if peri_rvalid pops in the same cycle. Issue resumes the next cycle.
- peri_rvalid with count==0: no host_rvalid, nothing popped; error condition.
- Reset mid-transaction: FIFO is cleared and late responses are treated as the empty-FIFO case. This is acceptable only because the peripherals share the same reset.

Latency: zero added cycles on the request path and zero on the response path; no combinational path from peri_gnt to peri_req.

Optional Feature:
- Macro: PERI_ARB_ERR_CHECK_EN.
- Defined: arb_err is set sticky (cleared only by reset) on either of:
  - peri_rvalid while the FIFO is empty;
  - a host deasserting req while in HOLD.
- Undefined: arb_err is tied 0 and the check logic is absent; the functional behaviour above is unchanged.

Decomposition:
- Package peri_arb_pkg:
  - typedef arb_state_e {ARB, HOLD};
  - localparam PERI_DW=32, PERI_AW=32, PERI_BEW=4.
  - function rr_pick(req, ptr) returning the winner index and a valid flag.
- Sub-module peri_arb_id_fifo: parameterised depth/width, synchronous active-low reset, with push/pop/full/empty/count and head output.

Test Plan:
1. Host0 alone writes addr 0x0000_1000 data 0xDEADBEEF, peri_gnt=1 same cycle, rvalid next cycle -> host_gnt=01 cycle 0, host_rvalid=01 cycle 1, rr_ptr=1.
2. Both hosts request continuously, peri_gnt always 1 -> grants alternate 01,10,01,10; rvalid routed in the same alternating order.
3. Host1 wins, peri_gnt held 0 for 3 cycles while host0 also requests -> peri_addr stays host1's 0x0000_2004 all 4 cycles; host1 granted on cycle 3, then host0 granted.
4. MAX_OUTSTANDING=2, two grants with no rvalid -> third request sees peri_req=0; rvalid in cycle n plus a pending request -> grant no earlier than n+1.
5. peri_rvalid pulsed with FIFO empty -> no host_rvalid; arb_err=1 with PERI_ARB_ERR_CHECK_EN, 0 without.
6. rst_n=0 for one cycle with 2 outstanding -> FIFO count=0, FSM=ARB, rr_ptr=0, all outputs 0 the next cycle.
